alu_serial_rx: RTL and testbench

- ALU-side deserializer for the serial command link driven on `sin` by the ALU testbench BFM.
- Reassembles 8 data frames plus 1 command frame into parallel operands A, B and a 3-bit op.
- Checks framing, frame count, CRC4 and op legality, then presents one result pulse per packet to the ALU core.

---
 rtl/alu_serial_rx.sv | 191 +++++++++++++++++++
 tb/tb_alu_serial_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_rx.sv
// Deserializer for the ALU serial command link: rebuilds operands A/B and the op
// from 8 data frames + 1 command frame, checks framing, count, CRC4 and op legality.
//
// state     | meaning
// S_IDLE    | waiting for a start bit (or for sin high after a framing error)
// S_TYPE    | sampling the frame type bit
// S_PAYLOAD | shifting in 8 payload bits, MSB first
// S_STOP    | sampling the stop bit and processing the frame
`timescale 1ns/1ps
module alu_serial_rx #(
  parameter int DATA_FRAMES = 8,
  parameter int OP_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sin,
  output logic [31:0]     a,
  output logic [31:0]     b,
  output logic [OP_W-1:0] op,
  output logic            out_valid,
  output logic            err_data,
  output logic            err_crc,
  output logic            err_op
);

  localparam int CNT_W = $clog2(DATA_FRAMES + 2);
  localparam int HALF  = DATA_FRAMES / 2;

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              type_q, type_d;
  logic [7:0]        shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        crc_q, crc_d;
  logic [31:0]       a_sh_q, a_sh_d;
  logic [31:0]       b_sh_q, b_sh_d;
  logic              wait_hi_q, wait_hi_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;
  logic              err_data_q, err_data_d;
  logic              err_crc_q, err_crc_d;
  logic              err_op_q, err_op_d;

  logic [OP_W-1:0]   op_rx;
  logic [3:0]        crc_fin;
  logic              op_legal;
  logic              e_data, e_crc, e_op;

  // x^4 + x + 1, one message bit per step
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    type_d     = type_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    wait_hi_d  = wait_hi_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    valid_d    = 1'b0;
    err_data_d = err_data_q;
    err_crc_d  = err_crc_q;
    err_op_d   = err_op_q;

    // The trailing marker bit and op bits are folded in here, unrolled, at the command stop bit
    op_rx   = shift_q[OP_W+3:4];
    crc_fin = crc_step(crc_q, 1'b1);
    for (int i = OP_W - 1; i >= 0; i--) begin
      crc_fin = crc_step(crc_fin, op_rx[i]);
    end
    op_legal = (op_rx == OP_W'(0)) || (op_rx == OP_W'(1)) ||
               (op_rx == OP_W'(4)) || (op_rx == OP_W'(5));
    e_data   = (cnt_q != CNT_W'(DATA_FRAMES));
    e_crc    = !e_data && (crc_fin != shift_q[3:0]);
    e_op     = !e_data && !e_crc && !op_legal;

    case (state_q)
      S_IDLE: begin
        if (wait_hi_q) begin
          if (sin) wait_hi_d = 1'b0;
        end else if (!sin) begin
          state_d = S_TYPE;
        end
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd7;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        shift_d = {shift_q[6:0], sin};
        if (!type_q && (cnt_q < CNT_W'(DATA_FRAMES))) crc_d = crc_step(crc_q, sin);
        if (bit_cnt_q == 3'd0) state_d = S_STOP;
        else                   bit_cnt_d = bit_cnt_q - 3'd1;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          valid_d    = 1'b1;
          err_data_d = 1'b1;
          err_crc_d  = 1'b0;
          err_op_d   = 1'b0;
          cnt_d      = '0;
          crc_d      = '0;
          wait_hi_d  = 1'b1;
        end else if (!type_q) begin
          if (cnt_q < CNT_W'(DATA_FRAMES)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q < CNT_W'(HALF)) b_sh_d = {b_sh_q[23:0], shift_q};
            else                      a_sh_d = {a_sh_q[23:0], shift_q};
          end else begin
            cnt_d = CNT_W'(DATA_FRAMES + 1);
          end
        end else begin
          valid_d    = 1'b1;
          op_d       = op_rx;
          err_data_d = e_data;
          err_crc_d  = e_crc;
          err_op_d   = e_op;
          if (!e_data && !e_crc && !e_op) begin
            a_d = a_sh_q;
            b_d = b_sh_q;
          end
          cnt_d = '0;
          crc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      type_q     <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      wait_hi_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      valid_q    <= 1'b0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      type_q     <= type_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      wait_hi_q  <= wait_hi_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
      err_data_q <= err_data_d;
      err_crc_q  <= err_crc_d;
      err_op_q   <= err_op_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign out_valid = valid_q;
  assign err_data  = err_data_q;
  assign err_crc   = err_crc_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Scoreboard bench for alu_serial_rx: directed packets from the test plan, then
// randomized packets checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_alu_serial_rx;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        chk_op;
    logic        ed;
    logic        ec;
    logic        eo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        out_valid, err_data, err_crc, err_op;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  pkt_data [12];
  logic [31:0] mdl_a = '0;
  logic [31:0] mdl_b = '0;

  alu_serial_rx #(.DATA_FRAMES(8), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .sin(sin),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
  );

  always #5 clk = ~clk;

  // CRC as the remainder of msg * x^4 divided by x^4 + x + 1
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] v;
    v = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    end
    return v[3:0];
  endfunction

  function automatic exp_t mk(input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] eop,
                              input logic ed, input logic ec, input logic eo);
    exp_t e;
    e.a = ea; e.b = eb; e.op = eop; e.chk_op = 1'b1; e.ed = ed; e.ec = ec; e.eo = eo;
    return e;
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop_ok);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop_ok);
  endtask

  task automatic model(input int n, input logic [7:0] cmd, input int fe, output exp_t e);
    logic [31:0] ma, mb;
    logic [2:0]  mop;
    mb  = {pkt_data[0], pkt_data[1], pkt_data[2], pkt_data[3]};
    ma  = {pkt_data[4], pkt_data[5], pkt_data[6], pkt_data[7]};
    mop = cmd[6:4];
    e.op = mop;
    if (fe >= 0 && fe <= n) begin
      e.chk_op = 1'b0; e.ed = 1'b1; e.ec = 1'b0; e.eo = 1'b0;
    end else begin
      e.chk_op = 1'b1;
      e.ed = (n != 8);
      e.ec = !e.ed && (crc_ref({mb, ma, 1'b1, mop}) != cmd[3:0]);
      e.eo = !e.ed && !e.ec && !(mop inside {3'd0, 3'd1, 3'd4, 3'd5});
      if (!e.ed && !e.ec && !e.eo) begin
        mdl_a = ma;
        mdl_b = mb;
      end
    end
    e.a = mdl_a;
    e.b = mdl_b;
  endtask

  task automatic run_packet(input int n, input logic [7:0] cmd, input int fe, input int gap,
                            input bit use_e, input exp_t e_in);
    exp_t e;
    if (use_e) begin
      e = e_in;
      mdl_a = e.a;
      mdl_b = e.b;
    end else begin
      model(n, cmd, fe, e);
    end
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      send_frame(1'b0, pkt_data[i], i != fe);
      if (i == fe) begin
        idle(2);
        return;
      end
      idle($urandom_range(0, gap));
    end
    send_frame(1'b1, cmd, fe != n);
    idle(2);
  endtask

  task automatic load_add();
    for (int i = 0; i < 12; i++) pkt_data[i] = 8'h00;
    pkt_data[3] = 8'h02;
    pkt_data[7] = 8'h01;
    pkt_data[8] = 8'hAA;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({a, b, op, out_valid, err_data, err_crc, err_op} !== '0)
      $display("FAIL %s: a=%h b=%h op=%b v=%b ed=%b ec=%b eo=%b, required all zero",
               name, a, b, op, out_valid, err_data, err_crc, err_op);
    if ({a, b, op, out_valid, err_data, err_crc, err_op} !== '0) n_fail++;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: out_valid=1, required no packet close");
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if ({err_data, err_crc, err_op} !== {mon_e.ed, mon_e.ec, mon_e.eo}) begin
          n_fail++;
          $display("FAIL err_flags: got d/c/o=%b%b%b, required %b%b%b",
                   err_data, err_crc, err_op, mon_e.ed, mon_e.ec, mon_e.eo);
        end
        n_checks++;
        if (a !== mon_e.a || b !== mon_e.b || (mon_e.chk_op && op !== mon_e.op)) begin
          n_fail++;
          $display("FAIL operands: got a=%h b=%h op=%b, required a=%h b=%h op=%b (op checked=%b)",
                   a, b, op, mon_e.a, mon_e.b, mon_e.op, mon_e.chk_op);
        end
      end
    end
  end

  initial begin
    exp_t none;
    int   n, fe, r;
    logic [2:0] rop;
    logic [7:0] cmd;
    none = mk('0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    idle(2);

    load_add();
    run_packet(8, 8'h4C, -1, 0, 1, mk(32'd1, 32'd2, 3'b100, 1'b0, 1'b0, 1'b0));
    run_packet(8, 8'h4D, -1, 0, 1, mk(32'd1, 32'd2, 3'b100, 1'b0, 1'b1, 1'b0));
    run_packet(7, 8'h4C, -1, 0, 1, mk(32'd1, 32'd2, 3'b100, 1'b1, 1'b0, 1'b0));
    run_packet(9, 8'h4C, -1, 0, 1, mk(32'd1, 32'd2, 3'b100, 1'b1, 1'b0, 1'b0));
    run_packet(8, 8'h35, -1, 0, 1, mk(32'd1, 32'd2, 3'b011, 1'b0, 1'b0, 1'b1));
    none = mk(32'd1, 32'd2, 3'b000, 1'b1, 1'b0, 1'b0);
    none.chk_op = 1'b0;
    run_packet(8, 8'h4C, 3, 0, 1, none);
    run_packet(8, 8'h4C, -1, 0, 1, mk(32'd1, 32'd2, 3'b100, 1'b0, 1'b0, 1'b0));

    // Reset while frame 5 is mid-payload
    for (int i = 0; i < 5; i++) send_frame(1'b0, pkt_data[i], 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("reset_mid_packet");
    mdl_a = '0;
    mdl_b = '0;
    idle(3);
    run_packet(8, 8'h4C, -1, 0, 1, mk(32'd1, 32'd2, 3'b100, 1'b0, 1'b0, 1'b0));

    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 12; i++) pkt_data[i] = 8'($urandom);
      r = $urandom_range(0, 9);
      n = (r < 7) ? 8 : (r == 7) ? 7 : (r == 8) ? 9 : 0;
      fe = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n) : -1;
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        cmd = {1'b0, rop, crc_ref({pkt_data[0], pkt_data[1], pkt_data[2], pkt_data[3],
                                   pkt_data[4], pkt_data[5], pkt_data[6], pkt_data[7], 1'b1, rop})};
      else
        cmd = {1'b0, rop, 4'($urandom)};
      run_packet(n, cmd, fe, 3, 0, none);
    end

    idle(10);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_out_valid: %0d packets outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
